// File: rtl/diag_pkg.sv
// Shared constants and types for the diagnostics SPI port.
// Contents: opcode values, default parameter values, command FSM state type.
package diag_pkg;

  localparam int unsigned ConfigBitsDefault = 5;
  localparam int unsigned VramAwDefault     = 11;

  localparam logic [7:0] OpHalt   = 8'h01;
  localparam logic [7:0] OpRun    = 8'h02;
  localparam logic [7:0] OpRead   = 8'h03;
  localparam logic [7:0] OpWrite  = 8'h04;
  localparam logic [7:0] OpSetCfg = 8'h05;
  localparam logic [7:0] OpVrDump = 8'h06;
  localparam logic [7:0] OpSetDis = 8'h07;
  localparam logic [7:0] OpStatus = 8'h08;

  typedef enum logic [3:0] {
    StIdle,
    StCfg,
    StDis,
    StRdHi,
    StRdLo,
    StRead,
    StWrHi,
    StWrLo,
    StWrite,
    StVram,
    StIgnore
  } diag_state_e;

endpackage

// File: rtl/spi_slave_byte.sv
// SPI mode-0 byte slave, MSB first, oversampled by the system clock.
// Ports:
//   clk_i, rst_ni        system clock, synchronous active-low reset
//   sclk_i, cs_ni, mosi_i raw asynchronous SPI pins (each 2-flop synchronised)
//   tx_load_i, tx_byte_i  load the transmit shifter with the next response byte
//   miso_o               slave-to-host data, updated on SCLK fall
//   rx_byte_o, rx_done_o received byte, valid for the one clk rx_done_o is high
//   cs_active_o          synchronised chip select is asserted (low on the pin)
module spi_slave_byte (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sclk_i,
  input  logic       cs_ni,
  input  logic       mosi_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  output logic       miso_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_o,
  output logic       cs_active_o
);

  logic [1:0] sclk_sync_d, sclk_sync_q;
  logic [1:0] cs_sync_d, cs_sync_q;
  logic [1:0] mosi_sync_d, mosi_sync_q;
  logic       sclk_prev_d, sclk_prev_q;
  logic [2:0] bit_cnt_d, bit_cnt_q;
  logic [7:0] rx_shift_d, rx_shift_q;
  logic       rx_done_d, rx_done_q;
  logic [7:0] tx_shift_d, tx_shift_q;
  logic       miso_d, miso_q;

  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[0], sclk_i};
    cs_sync_d   = {cs_sync_q[0], cs_ni};
    mosi_sync_d = {mosi_sync_q[0], mosi_i};
    sclk_prev_d = sclk_s;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_done_d   = 1'b0;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;

    if (cs_s) begin
      // Deselected: drop any partial byte and pending response.
      bit_cnt_d  = '0;
      tx_shift_d = '0;
      miso_d     = 1'b0;
    end else begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        rx_done_d  = (bit_cnt_q == 3'd7);
      end
      if (sclk_fall) begin
        // Zero fill means the line idles low once a response has shifted out.
        miso_d     = tx_shift_q[7];
        tx_shift_d = {tx_shift_q[6:0], 1'b0};
      end
      if (tx_load_i) begin
        tx_shift_d = tx_byte_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_done_q   <= 1'b0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_done_q   <= rx_done_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
    end
  end

  assign miso_o      = miso_q;
  assign rx_byte_o   = rx_shift_q;
  assign rx_done_o   = rx_done_q;
  assign cs_active_o = ~cs_s;

endmodule

// File: rtl/diagnostics.sv
// Diagnostics SPI port: host-side control of CPU halt, configuration, memory
// disables, and a byte-wide RAM read/write path, all driven by SPI commands.
// Ports:
//   clk, reset             system clock, synchronous active-low reset
//   diag_spi_cs_in, spi_clk_in, spi_miso, diag_spi_out   SPI slave pins
//   halt                   CPU halt request
//   diag_ram_*, ram_dataout RAM bus (parent muxes it in when halt=1)
//   configuration/config_byte  power-up and active configuration
//   ram/rom_disable_in/out power-up and active memory disables
//   vram_*                 video RAM read port
// Build option: define DIAG_VRAM_EN to enable the VRAM dump command; without it
// the VRAM address is tied to zero and that opcode is ignored.
module diagnostics
  import diag_pkg::*;
#(
  parameter int unsigned CONFIG_BITS = ConfigBitsDefault,
  parameter int unsigned VRAM_AW     = VramAwDefault
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   halt,
  input  logic                   diag_spi_cs_in,
  input  logic                   spi_clk_in,
  input  logic                   spi_miso,
  output logic                   diag_spi_out,
  output logic [15:0]            diag_ram_address,
  input  logic [7:0]             ram_dataout,
  output logic [7:0]             diag_ram_datain,
  output logic                   diag_ram_we,
  output logic                   diag_ram_cs,
  input  logic [CONFIG_BITS-1:0] configuration,
  output logic [CONFIG_BITS-1:0] config_byte,
  output logic [VRAM_AW-1:0]     vram_read_address,
  input  logic [7:0]             vram_output,
  output logic                   vram_read_clock,
  input  logic [VRAM_AW-1:0]     vram_size,
  input  logic                   ram_disable_in,
  input  logic                   rom_disable_in,
  output logic                   ram_disable_out,
  output logic                   rom_disable_out
);

  diag_state_e state_d, state_q;

  logic                   halt_d, halt_q;
  logic [CONFIG_BITS-1:0] config_d, config_q;
  logic                   ram_dis_d, ram_dis_q;
  logic                   rom_dis_d, rom_dis_q;
  logic [15:0]            addr_d, addr_q;
  logic [7:0]             addr_hi_d, addr_hi_q;
  logic [7:0]             datain_d, datain_q;
  logic                   ram_cs_d, ram_cs_q;
  logic                   ram_we_d, ram_we_q;
  logic                   rd_cap_d, rd_cap_q;

  logic                   tx_load;
  logic [7:0]             tx_byte;
  logic [7:0]             rx_byte;
  logic                   rx_done;
  logic                   cs_active;
  logic [7:0]             status_byte;
  logic [CONFIG_BITS-1:0] cfg_from_rx;

  spi_slave_byte u_spi (
    .clk_i       (clk),
    .rst_ni      (reset),
    .sclk_i      (spi_clk_in),
    .cs_ni       (diag_spi_cs_in),
    .mosi_i      (spi_miso),
    .tx_load_i   (tx_load),
    .tx_byte_i   (tx_byte),
    .miso_o      (diag_spi_out),
    .rx_byte_o   (rx_byte),
    .rx_done_o   (rx_done),
    .cs_active_o (cs_active)
  );

  // Status reports the low five configuration bits, zero-filled if narrower.
  always_comb begin
    status_byte    = '0;
    status_byte[7] = halt_q;
    status_byte[6] = rom_dis_q;
    status_byte[5] = ram_dis_q;
    for (int i = 0; i < 5; i++) begin
      if (i < int'(CONFIG_BITS)) status_byte[i] = config_q[i];
    end
  end

  always_comb begin
    cfg_from_rx = '0;
    for (int i = 0; i < int'(CONFIG_BITS); i++) begin
      if (i < 8) cfg_from_rx[i] = rx_byte[i];
    end
  end

`ifdef DIAG_VRAM_EN
  logic [VRAM_AW-1:0] vaddr_d, vaddr_q, vaddr_inc;
  logic               vcap_d, vcap_q;
  logic               vram_start, vram_step;

  // Address goes out one clk ahead of the capture into the tx shifter.
  always_comb begin
    vaddr_inc = vaddr_q + VRAM_AW'(1);
    vaddr_d   = vaddr_q;
    vcap_d    = 1'b0;
    if (vram_start) begin
      vaddr_d = '0;
      vcap_d  = 1'b1;
    end else if (vram_step) begin
      vaddr_d = (vaddr_inc == vram_size) ? '0 : vaddr_inc;
      vcap_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vaddr_q <= '0;
      vcap_q  <= 1'b0;
    end else begin
      vaddr_q <= vaddr_d;
      vcap_q  <= vcap_d;
    end
  end

  assign vram_read_address = vaddr_q;
`else
  logic unused_vram;
  assign unused_vram       = ^{vram_output, vram_size};
  assign vram_read_address = '0;
`endif

  always_comb begin
    state_d   = state_q;
    halt_d    = halt_q;
    config_d  = config_q;
    ram_dis_d = ram_dis_q;
    rom_dis_d = rom_dis_q;
    addr_d    = addr_q;
    addr_hi_d = addr_hi_q;
    datain_d  = datain_q;
    ram_cs_d  = 1'b0;
    ram_we_d  = 1'b0;
    rd_cap_d  = 1'b0;
    tx_load   = 1'b0;
    tx_byte   = '0;
`ifdef DIAG_VRAM_EN
    vram_start = 1'b0;
    vram_step  = 1'b0;
`endif

    // Advance after each write strobe so the next data byte lands one higher.
    if (ram_we_q) addr_d = addr_q + 16'd1;

    // Read data is sampled the clk after the read strobe.
    if (rd_cap_q) begin
      tx_load = 1'b1;
      tx_byte = ram_dataout;
    end
`ifdef DIAG_VRAM_EN
    if (vcap_q) begin
      tx_load = 1'b1;
      tx_byte = vram_output;
    end
`endif

    if (!cs_active) begin
      state_d = StIdle;
    end else if (rx_done) begin
      unique case (state_q)
        StIdle: begin
          state_d = StIgnore;
          case (rx_byte)
            OpHalt:   halt_d  = 1'b1;
            OpRun:    halt_d  = 1'b0;
            OpRead:   state_d = StRdHi;
            OpWrite:  state_d = StWrHi;
            OpSetCfg: state_d = StCfg;
            OpSetDis: state_d = StDis;
            OpStatus: begin
              tx_load = 1'b1;
              tx_byte = status_byte;
            end
            OpVrDump: begin
`ifdef DIAG_VRAM_EN
              state_d    = StVram;
              vram_start = 1'b1;
`endif
            end
            default: ;
          endcase
        end
        StCfg: begin
          config_d = cfg_from_rx;
          state_d  = StIgnore;
        end
        StDis: begin
          ram_dis_d = rx_byte[0];
          rom_dis_d = rx_byte[1];
          state_d   = StIgnore;
        end
        StRdHi: begin
          addr_hi_d = rx_byte;
          state_d   = StRdLo;
        end
        StRdLo: begin
          addr_d   = {addr_hi_q, rx_byte};
          ram_cs_d = 1'b1;
          rd_cap_d = 1'b1;
          state_d  = StRead;
        end
        StRead: begin
          // The byte just clocked out carried RAM[addr]; prefetch addr+1.
          addr_d   = addr_q + 16'd1;
          ram_cs_d = 1'b1;
          rd_cap_d = 1'b1;
        end
        StWrHi: begin
          addr_hi_d = rx_byte;
          state_d   = StWrLo;
        end
        StWrLo: begin
          addr_d  = {addr_hi_q, rx_byte};
          state_d = StWrite;
        end
        StWrite: begin
          ram_cs_d = 1'b1;
          ram_we_d = 1'b1;
          datain_d = rx_byte;
        end
        StVram: begin
`ifdef DIAG_VRAM_EN
          vram_step = 1'b1;
`endif
        end
        StIgnore: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      halt_q    <= 1'b0;
      config_q  <= configuration;
      ram_dis_q <= ram_disable_in;
      rom_dis_q <= rom_disable_in;
      addr_q    <= '0;
      addr_hi_q <= '0;
      datain_q  <= '0;
      ram_cs_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      rd_cap_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      halt_q    <= halt_d;
      config_q  <= config_d;
      ram_dis_q <= ram_dis_d;
      rom_dis_q <= rom_dis_d;
      addr_q    <= addr_d;
      addr_hi_q <= addr_hi_d;
      datain_q  <= datain_d;
      ram_cs_q  <= ram_cs_d;
      ram_we_q  <= ram_we_d;
      rd_cap_q  <= rd_cap_d;
    end
  end

  assign halt             = halt_q;
  assign config_byte      = config_q;
  assign ram_disable_out  = ram_dis_q;
  assign rom_disable_out  = rom_dis_q;
  assign diag_ram_address = addr_q;
  assign diag_ram_datain  = datain_q;
  assign diag_ram_cs      = ram_cs_q;
  assign diag_ram_we      = ram_we_q;
  assign vram_read_clock  = clk;

endmodule

// File: tb/tb_diagnostics.sv
// Bench for diagnostics: drives SPI mode-0 transactions and compares every
// returned byte, the control outputs and the RAM write stream against a
// command-level model of the port.
module tb_diagnostics;

  localparam int unsigned Half = 8;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        cs_n;
  logic        sclk;
  logic        mosi;
  logic        diag_spi_out;
  logic [15:0] diag_ram_address;
  logic [7:0]  ram_dataout;
  logic [7:0]  diag_ram_datain;
  logic        diag_ram_we;
  logic        diag_ram_cs;
  logic [4:0]  configuration;
  logic [4:0]  config_byte;
  logic [10:0] vram_read_address;
  logic [7:0]  vram_output;
  logic        vram_read_clock;
  logic [10:0] vram_size;
  logic        ram_disable_in;
  logic        rom_disable_in;
  logic        ram_disable_out;
  logic        rom_disable_out;

  always #5 clk = ~clk;

  diagnostics dut (
    .clk               (clk),
    .reset             (reset),
    .halt              (halt),
    .diag_spi_cs_in    (cs_n),
    .spi_clk_in        (sclk),
    .spi_miso          (mosi),
    .diag_spi_out      (diag_spi_out),
    .diag_ram_address  (diag_ram_address),
    .ram_dataout       (ram_dataout),
    .diag_ram_datain   (diag_ram_datain),
    .diag_ram_we       (diag_ram_we),
    .diag_ram_cs       (diag_ram_cs),
    .configuration     (configuration),
    .config_byte       (config_byte),
    .vram_read_address (vram_read_address),
    .vram_output       (vram_output),
    .vram_read_clock   (vram_read_clock),
    .vram_size         (vram_size),
    .ram_disable_in    (ram_disable_in),
    .rom_disable_in    (rom_disable_in),
    .ram_disable_out   (ram_disable_out),
    .rom_disable_out   (rom_disable_out)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5A);
  endfunction

  // Environment RAM (owned by the monitor process) and VRAM.
  logic [7:0]  bus_mem  [65536];
  logic [7:0]  vram_mem [2048];
  logic [23:0] obs_log  [1024];
  int          obs_cnt     = 0;
  int          we_run      = 0;
  int          wide_pulses = 0;
  int          stray_we    = 0;

  assign ram_dataout = bus_mem[diag_ram_address];
  assign vram_output = vram_mem[vram_read_address];

  initial begin
    for (int a = 0; a < 65536; a++) bus_mem[a] = init_val(a);
    forever begin
      @(negedge clk);
      if (diag_ram_cs && diag_ram_we) begin
        if (we_run == 0 && obs_cnt < 1024) begin
          obs_log[obs_cnt] = {diag_ram_address, diag_ram_datain};
          obs_cnt++;
        end
        bus_mem[diag_ram_address] = diag_ram_datain;
        we_run++;
      end else begin
        if (we_run > 1) wide_pulses++;
        we_run = 0;
      end
      if (diag_ram_we && !diag_ram_cs) stray_we++;
    end
  end

  // Command-level model.
  logic [7:0]  ref_mem [65536];
  logic        m_halt;
  logic [4:0]  m_cfg;
  logic        m_ramdis;
  logic        m_romdis;
  logic [23:0] exp_wr[$];
  int          obs_rd = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_txn(input logic [7:0] b[$], output logic [7:0] e[$]);
    logic [15:0] a;
    int          v;
    e = {};
    foreach (b[k]) e.push_back(8'h00);
    if (b.size() == 0) return;
    case (b[0])
      8'h01: m_halt = 1'b1;
      8'h02: m_halt = 1'b0;
      8'h05: if (b.size() > 1) m_cfg = b[1][4:0];
      8'h07: if (b.size() > 1) begin
        m_ramdis = b[1][0];
        m_romdis = b[1][1];
      end
      8'h08: if (b.size() > 1) e[1] = {m_halt, m_romdis, m_ramdis, m_cfg};
      8'h03: if (b.size() > 3) begin
        a = {b[1], b[2]};
        for (int k = 3; k < b.size(); k++) begin
          e[k] = ref_mem[a];
          a++;
        end
      end
      8'h04: if (b.size() > 3) begin
        a = {b[1], b[2]};
        for (int k = 3; k < b.size(); k++) begin
          ref_mem[a] = b[k];
          exp_wr.push_back({a, b[k]});
          a++;
        end
      end
`ifdef DIAG_VRAM_EN
      8'h06: begin
        v = 0;
        for (int k = 1; k < b.size(); k++) begin
          e[k] = vram_mem[v];
          v = (v + 1 == int'(vram_size)) ? 0 : v + 1;
        end
      end
`endif
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      repeat (Half) @(negedge clk);
      sclk  = 1'b1;
      rx[i] = diag_spi_out;
      repeat (Half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (Half) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (Half) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * Half) @(negedge clk);
  endtask

  task automatic spi_txn(input logic [7:0] tx[$], output logic [7:0] rx[$]);
    logic [7:0] r;
    rx = {};
    cs_low();
    foreach (tx[k]) begin
      send_byte(tx[k], 8, r);
      rx.push_back(r);
    end
    cs_high();
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".halt"}, halt, m_halt);
    chk({tag, ".cfg"}, config_byte, m_cfg);
    chk({tag, ".ramdis"}, ram_disable_out, m_ramdis);
    chk({tag, ".romdis"}, rom_disable_out, m_romdis);
    chk({tag, ".ramcs_idle"}, diag_ram_cs, 1'b0);
    chk({tag, ".ramwe_idle"}, diag_ram_we, 1'b0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, ".wr_count"}, obs_cnt - obs_rd, exp_wr.size());
    while (obs_rd < obs_cnt && exp_wr.size() > 0) begin
      chk($sformatf("%s.wr%0d", tag, obs_rd), obs_log[obs_rd], exp_wr.pop_front());
      obs_rd++;
    end
    obs_rd = obs_cnt;
    exp_wr = {};
  endtask

  task automatic do_txn(input string tag, input logic [7:0] b[$]);
    logic [7:0] e[$];
    logic [7:0] r[$];
    model_txn(b, e);
    spi_txn(b, r);
    foreach (e[k]) chk($sformatf("%s.rx%0d", tag, k), r[k], e[k]);
    check_state(tag);
    check_writes(tag);
  endtask

  task automatic apply_reset(input logic [4:0] cfg, input logic rd, input logic rmd);
    configuration  = cfg;
    ram_disable_in = rd;
    rom_disable_in = rmd;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_halt   = 1'b0;
    m_cfg    = cfg;
    m_ramdis = rd;
    m_romdis = rmd;
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  dummy;
    logic [15:0] last_wr;
    int          sel;
    int          nb;

    cs_n      = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    reset     = 1'b0;
    vram_size = 11'd2;
    last_wr   = 16'h0100;
    configuration  = '0;
    ram_disable_in = 1'b0;
    rom_disable_in = 1'b0;
    for (int a = 0; a < 65536; a++) ref_mem[a] = init_val(a);
    for (int a = 0; a < 2048; a++) vram_mem[a] = 8'($urandom);
    @(negedge clk);

    // Reset values.
    apply_reset(5'h03, 1'b1, 1'b0);
    chk("rst.cfg", config_byte, 5'h03);
    chk("rst.ramdis", ram_disable_out, 1'b1);
    chk("rst.romdis", rom_disable_out, 1'b0);
    chk("rst.halt", halt, 1'b0);
    chk("rst.ramcs", diag_ram_cs, 1'b0);
    chk("rst.ramwe", diag_ram_we, 1'b0);
    chk("rst.addr", diag_ram_address, 16'h0000);
    chk("rst.datain", diag_ram_datain, 8'h00);
    chk("rst.vaddr", vram_read_address, 11'h000);
    chk("rst.miso", diag_spi_out, 1'b0);
    chk("rst.vclk", vram_read_clock, clk);
    configuration = 5'h1C;
    repeat (3) @(negedge clk);
    chk("rst.cfg_held", config_byte, 5'h03);

    // HALT then STATUS.
    apply_reset(5'h03, 1'b0, 1'b0);
    q = {8'h01};
    do_txn("halt", q);
    q = {8'h08, 8'h00, 8'h00};
    do_txn("status", q);

    // WRITE with two data bytes, then a write that wraps the address.
    q = {8'h04, 8'h12, 8'h34, 8'hAA, 8'h55};
    do_txn("write", q);
    q = {8'h04, 8'hFF, 8'hFF, 8'h11, 8'h22};
    do_txn("write_wrap", q);

    // READ across the top of the address space.
    q = {8'h03, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
    do_txn("read_wrap", q);
    q = {8'h03, 8'h12, 8'h34, 8'h00, 8'h00};
    do_txn("read_back", q);

    // SETCFG, then a truncated opcode that must have no effect.
    q = {8'h05, 8'h1F};
    do_txn("setcfg", q);
    cs_low();
    send_byte(8'h02, 7, dummy);
    cs_high();
    check_state("abort");
    q = {8'h08, 8'h00};
    do_txn("status2", q);

    // SETDIS and an undefined opcode.
    q = {8'h07, 8'h02};
    do_txn("setdis", q);
    q = {8'hA5, 8'h00, 8'h00};
    do_txn("undef", q);

    // VRAM dump opcode.
    q = {8'h06, 8'h00, 8'h00, 8'h00};
    do_txn("vrdump", q);
`ifndef DIAG_VRAM_EN
    chk("vrdump.vaddr", vram_read_address, 11'h000);
`endif

    // Randomised command mix.
    for (int n = 0; n < 14; n++) begin
      sel = $urandom_range(0, 7);
      nb  = $urandom_range(1, 3);
      q   = {};
      case (sel)
        0: q = {8'h01};
        1: q = {8'h02};
        2: q = {8'h05, 8'($urandom)};
        3: q = {8'h07, 8'($urandom)};
        4: q = {8'h08, 8'h00, 8'h00};
        5: begin
          last_wr = 16'($urandom);
          q = {8'h04, last_wr[15:8], last_wr[7:0]};
          for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
        end
        6: begin
          q = {8'h03, last_wr[15:8], last_wr[7:0]};
          for (int k = 0; k <= nb; k++) q.push_back(8'h00);
        end
        default: q = {8'($urandom_range(9, 255)), 8'h00};
      endcase
      do_txn($sformatf("rnd%0d", n), q);
    end

    // Reset in the middle of a WRITE data byte: the write must not happen.
    q = {8'h01};
    do_txn("pre_rst", q);
    cs_low();
    send_byte(8'h04, 8, dummy);
    send_byte(8'h00, 8, dummy);
    send_byte(8'h10, 8, dummy);
    send_byte(8'h5A, 4, dummy);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    m_halt   = 1'b0;
    m_cfg    = configuration;
    m_ramdis = ram_disable_in;
    m_romdis = rom_disable_in;
    cs_high();
    check_state("midrst");
    check_writes("midrst");
    chk("midrst.miso", diag_spi_out, 1'b0);

    chk("we_pulse_width", wide_pulses, 0);
    chk("we_without_cs", stray_we, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
